// File: rtl/ghost_movement.sv
// ghost_movement
//   Position controller for one ghost sprite. In CHASE it steps the ghost
//   toward Pac-Man once per move tick (STEP pixels, never past Pac-Man's
//   coordinate on the moving axis, clamped to the arena), flags a bounding
//   box overlap as CAUGHT, and drives a zero-latency per-pixel fill.
//
//   Optional feature: define GHOST_RANDOM_EN to add a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11, seed 16'hACE1) that occasionally diverts a step onto
//   the non-preferred axis. Undefined: pure greedy chase.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start             : pulse, IDLE -> CHASE
//   ack               : pulse, CAUGHT -> IDLE with respawn
//   pacX, pacY        : Pac-Man top-left position
//   hCount, vCount    : display counters for the fill output
//   ghostX, ghostY    : registered ghost top-left position
//   ghostFill         : combinational, current pixel inside the ghost
//   caught            : registered, high while in CAUGHT
//   state             : IDLE=00, CHASE=01, CAUGHT=10
module ghost_movement #(
  parameter int unsigned START_X     = 300,
  parameter int unsigned START_Y     = 220,
  parameter int unsigned SIZE        = 10,
  parameter int unsigned STEP        = 1,
  parameter int unsigned MOVE_PERIOD = 1_000_000,
  parameter int unsigned X_MIN       = 144,
  parameter int unsigned X_MAX       = 774,
  parameter int unsigned Y_MIN       = 35,
  parameter int unsigned Y_MAX       = 505
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [9:0] ghostX,
  output logic [9:0] ghostY,
  output logic       ghostFill,
  output logic       caught,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHASE  = 2'b01,
    CAUGHT = 2'b10
  } state_t;

  localparam int unsigned     CNT_W    = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [9:0]      START_XV = 10'(START_X);
  localparam logic [9:0]      START_YV = 10'(START_Y);
  localparam logic [9:0]      X_MINV   = 10'(X_MIN);
  localparam logic [9:0]      X_MAXV   = 10'(X_MAX);
  localparam logic [9:0]      Y_MINV   = 10'(Y_MIN);
  localparam logic [9:0]      Y_MAXV   = 10'(Y_MAX);
  localparam logic [10:0]     STEP_V   = 11'(STEP);
  localparam logic [10:0]     SIZE_V   = 11'(SIZE);

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             caught_q, caught_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               tick, collide;
  logic               pref_x, pref_y, move_x, move_y;

  // Step one axis toward the target: the step is limited to the remaining
  // distance, so pos +/- amt always stays within 0..1023, then clamped.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        neg,
                                           input logic [10:0] mag,
                                           input logic [9:0]  lo,
                                           input logic [9:0]  hi);
    logic [10:0] amt;
    logic [10:0] nxt;
    amt = (mag < STEP_V) ? mag : STEP_V;
    nxt = neg ? ({1'b0, pos} - amt) : ({1'b0, pos} + amt);
    if (nxt < {1'b0, lo}) begin
      nxt = {1'b0, lo};
    end else if (nxt > {1'b0, hi}) begin
      nxt = {1'b0, hi};
    end
    return nxt[9:0];
  endfunction

  assign dx  = $signed({1'b0, pacX}) - $signed({1'b0, x_q});
  assign dy  = $signed({1'b0, pacY}) - $signed({1'b0, y_q});
  assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);

  assign tick    = (state_q == CHASE) && (cnt_q == CNT_LAST);
  assign collide = (adx < SIZE_V) && (ady < SIZE_V);

  // Greedy axis choice; a tie goes to X.
  assign pref_x = (adx >= ady) && (dx != '0);
  assign pref_y = !pref_x && (dy != '0);

`ifdef GHOST_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb, divert, alt_x, alt_y;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign divert  = (lfsr_q[2:0] == 3'b000);
  // Diverting only happens when the other axis actually has distance left.
  assign alt_x   = pref_y && (dx != '0);
  assign alt_y   = pref_x && (dy != '0);
  assign move_x  = (divert && (alt_x || alt_y)) ? alt_x : pref_x;
  assign move_y  = (divert && (alt_x || alt_y)) ? alt_y : pref_y;

  always_comb begin
    lfsr_d = lfsr_q;
    if (tick) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign move_x = pref_x;
  assign move_y = pref_y;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    caught_d = caught_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = CHASE;
        end
      end
      CHASE: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        // Collision takes priority over a coincident move tick.
        if (collide) begin
          state_d  = CAUGHT;
          caught_d = 1'b1;
        end else if (tick) begin
          if (move_x) begin
            x_d = step_axis(x_q, dx[10], adx, X_MINV, X_MAXV);
          end else if (move_y) begin
            y_d = step_axis(y_q, dy[10], ady, Y_MINV, Y_MAXV);
          end
        end
      end
      CAUGHT: begin
        if (ack) begin
          state_d  = IDLE;
          x_d      = START_XV;
          y_d      = START_YV;
          caught_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= START_XV;
      y_q      <= START_YV;
      caught_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      caught_q <= caught_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ghostFill = ({1'b0, hCount} >= {1'b0, x_q}) && ({1'b0, hCount} < ({1'b0, x_q} + SIZE_V)) &&
                     ({1'b0, vCount} >= {1'b0, y_q}) && ({1'b0, vCount} < ({1'b0, y_q} + SIZE_V));

  assign ghostX = x_q;
  assign ghostY = y_q;
  assign caught = caught_q;
  assign state  = state_q;

endmodule

// File: tb/tb_ghost_movement.sv
// Self-checking bench for ghost_movement: three instances (STEP 1 / STEP 16 /
// STEP 8 with X_MAX 302), directed scenarios plus randomized chase traffic,
// all compared every cycle against a behavioural model.
module tb_ghost_movement;

  logic       clk;
  logic       rst;
  logic       st [3];
  logic       ak [3];
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic [9:0] hc, vc;
  logic [9:0] gx_o [3];
  logic [9:0] gy_o [3];
  logic       fill_o [3];
  logic       caught_o [3];
  logic [1:0] state_o [3];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: 0 idle, 1 chase, 2 caught
  int          ms [3];
  int          mx [3];
  int          my [3];
  int          mc [3];
  logic [15:0] ml [3];
  int          P_STEP [3] = '{1, 16, 8};
  int          P_XMAX [3] = '{774, 774, 302};
  int          tgt_x [3];
  int          tgt_y [3];

  ghost_movement #(.MOVE_PERIOD(4)) u_g0 (
    .clk(clk), .reset(rst), .start(st[0]), .ack(ak[0]), .pacX(px[0]), .pacY(py[0]),
    .hCount(hc), .vCount(vc), .ghostX(gx_o[0]), .ghostY(gy_o[0]),
    .ghostFill(fill_o[0]), .caught(caught_o[0]), .state(state_o[0]));

  ghost_movement #(.STEP(16), .MOVE_PERIOD(4)) u_g1 (
    .clk(clk), .reset(rst), .start(st[1]), .ack(ak[1]), .pacX(px[1]), .pacY(py[1]),
    .hCount(hc), .vCount(vc), .ghostX(gx_o[1]), .ghostY(gy_o[1]),
    .ghostFill(fill_o[1]), .caught(caught_o[1]), .state(state_o[1]));

  ghost_movement #(.STEP(8), .MOVE_PERIOD(4), .X_MAX(302)) u_g2 (
    .clk(clk), .reset(rst), .start(st[2]), .ack(ak[2]), .pacX(px[2]), .pacY(py[2]),
    .hCount(hc), .vCount(vc), .ghostX(gx_o[2]), .ghostY(gy_o[2]),
    .ghostFill(fill_o[2]), .caught(caught_o[2]), .state(state_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return (v < 0) ? -1 : 1;
  endfunction

  function automatic int mini(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ms[i] = 0; mx[i] = 300; my[i] = 220; mc[i] = 0; ml[i] = 16'hACE1;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int dx, dy, adx, ady;
    bit tick, coll, mvx, mvy;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (ms[i])
          0: begin
            mc[i] = 0;
            if (st[i]) ms[i] = 1;
          end
          1: begin
            dx   = int'(px[i]) - mx[i];
            dy   = int'(py[i]) - my[i];
            adx  = absi(dx);
            ady  = absi(dy);
            tick = (mc[i] == 3);
            mc[i] = (mc[i] + 1) % 4;
            coll = (adx < 10) && (ady < 10);
            mvx  = (adx >= ady) && (dx != 0);
            mvy  = !mvx && (dy != 0);
`ifdef GHOST_RANDOM_EN
            if (tick) begin
              if (ml[i][2:0] == 3'b000) begin
                if (mvx && dy != 0) begin mvx = 0; mvy = 1; end
                else if (mvy && dx != 0) begin mvx = 1; mvy = 0; end
              end
              ml[i] = {ml[i][0] ^ ml[i][2] ^ ml[i][3] ^ ml[i][5], ml[i][15:1]};
            end
`endif
            if (coll) begin
              ms[i] = 2;
            end else if (tick) begin
              if (mvx) mx[i] = clampi(mx[i] + sgn(dx) * mini(P_STEP[i], adx), 144, P_XMAX[i]);
              else if (mvy) my[i] = clampi(my[i] + sgn(dy) * mini(P_STEP[i], ady), 35, 505);
            end
          end
          default: begin
            if (ak[i]) begin
              ms[i] = 0; mx[i] = 300; my[i] = 220;
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    int hx, vy;
    bit fexp;
    hx = int'(hc);
    vy = int'(vc);
    for (int i = 0; i < 3; i++) begin
      fexp = (hx >= mx[i]) && (hx < mx[i] + 10) && (vy >= my[i]) && (vy < my[i] + 10);
      check($sformatf("g%0d.state", i), state_o[i], ms[i]);
      check($sformatf("g%0d.x", i), gx_o[i], mx[i]);
      check($sformatf("g%0d.y", i), gy_o[i], my[i]);
      check($sformatf("g%0d.caught", i), caught_o[i], (ms[i] == 2) ? 1 : 0);
      check($sformatf("g%0d.fill", i), fill_o[i], fexp);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse_start(input int i);
    st[i] = 1'b1;
    cycle();
    st[i] = 1'b0;
  endtask

  task automatic pulse_ack(input int i);
    ak[i] = 1'b1;
    cycle();
    ak[i] = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; ak[i] = 1'b0; px[i] = 10'd700; py[i] = 10'd400;
    end
    hc = 10'd300;
    vc = 10'd220;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;

    check("rst.x", gx_o[0], 300);
    check("rst.y", gy_o[0], 220);
    check("rst.state", state_o[0], 0);
    check("rst.caught", caught_o[0], 0);

    // Idle hold with wandering Pac-Man
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 3; i++) begin
        px[i] = 10'($urandom_range(150, 700));
        py[i] = 10'($urandom_range(40, 500));
      end
      cycle();
    end
    check("idle.x", gx_o[0], 300);
    check("idle.y", gy_o[0], 220);

    // Fill corners at the start position
    hc = 10'd300; vc = 10'd220; #1; check("fill.tl", fill_o[0], 1);
    hc = 10'd309; vc = 10'd229; #1; check("fill.br", fill_o[0], 1);
    hc = 10'd310; vc = 10'd220; #1; check("fill.right", fill_o[0], 0);
    hc = 10'd299; vc = 10'd220; #1; check("fill.left", fill_o[0], 0);
    for (int i = 0; i < 3; i++) begin
      px[i] = 10'd700; py[i] = 10'd400;
    end

    // Greedy chase on instance 0
    px[0] = 10'd320; py[0] = 10'd225;
    pulse_start(0);
    repeat (4) cycle();
`ifndef GHOST_RANDOM_EN
    check("greedy.x4", gx_o[0], 301);
`endif
    repeat (4) cycle();
`ifndef GHOST_RANDOM_EN
    check("greedy.x8", gx_o[0], 302);
    check("greedy.y8", gy_o[0], 220);
`endif
    guard = 0;
    while (state_o[0] != 2'b10 && guard < 200) begin
      cycle();
      guard++;
    end
    check("greedy.caught_in_time", (guard < 200) ? 1 : 0, 1);
`ifndef GHOST_RANDOM_EN
    check("greedy.caught_x", gx_o[0], 311);
    check("greedy.caught_y", gy_o[0], 220);
`endif
    pulse_start(0);
    check("caught.start_ignored", state_o[0], 2);
    pulse_ack(0);
    check("ack.x", gx_o[0], 300);
    check("ack.y", gy_o[0], 220);
    check("ack.caught", caught_o[0], 0);
    check("ack.state", state_o[0], 0);

    // Tie and overshoot limit on instance 1 (STEP 16)
    px[1] = 10'd312; py[1] = 10'd232;
    pulse_start(1);
    repeat (4) cycle();
`ifndef GHOST_RANDOM_EN
    check("tie.x", gx_o[1], 312);
    check("tie.y", gy_o[1], 220);
`endif
    repeat (4) cycle();
`ifndef GHOST_RANDOM_EN
    check("over.y", gy_o[1], 232);
`endif
    cycle();
    check("over.caught", caught_o[1], 1);
    check("over.state", state_o[1], 2);

    // Clamp on instance 2 (X_MAX 302)
    px[2] = 10'd600; py[2] = 10'd220;
    pulse_start(2);
    repeat (4) cycle();
    check("clamp.x4", gx_o[2], 302);
    repeat (40) cycle();
    check("clamp.x", gx_o[2], 302);
    check("clamp.y", gy_o[2], 220);

    // Collision coinciding with a tick on instance 0
    px[0] = 10'd320; py[0] = 10'd220;
    pulse_start(0);
    repeat (3) cycle();
    px[0] = 10'd305;
    cycle();
    check("prio.x", gx_o[0], 300);
    check("prio.state", state_o[0], 2);
    pulse_ack(0);

    // Asynchronous reset mid-chase
    #2;
    rst = 1'b1;
    #1;
    check("arst.x", gx_o[2], 300);
    check("arst.state", state_o[2], 0);
    cycle();
    rst = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (k % 50 == 0) begin
          tgt_x[i] = clampi(mx[i] + $urandom_range(0, 80) - 40, 0, 1023);
          tgt_y[i] = clampi(my[i] + $urandom_range(0, 80) - 40, 0, 1023);
        end
        px[i] = 10'(tgt_x[i]);
        py[i] = 10'(tgt_y[i]);
        st[i] = ($urandom_range(0, 15) == 0);
        ak[i] = ($urandom_range(0, 15) == 0);
      end
      hc = 10'(clampi(mx[0] + $urandom_range(0, 14) - 2, 0, 1023));
      vc = 10'(clampi(my[0] + $urandom_range(0, 14) - 2, 0, 1023));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
